// File: rtl/czstack_if.sv
// czstack_if: sequencer <-> call/return stack bundle.
// master drives PUSH/POP/DI/CLR_ERR; slave returns TOS/DEPTH/status.
interface czstack_if #(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_WIDTH = 4
);
  logic                   PUSH;
  logic                   POP;
  logic [PC_WIDTH-1:0]    DI;
  logic                   CLR_ERR;
  logic [PC_WIDTH-1:0]    TOS;
  logic [STACK_WIDTH:0]   DEPTH;
  logic                   EMPTY;
  logic                   FULL;
  logic                   OVF;
  logic                   UDF;

  modport master (
    output PUSH, POP, DI, CLR_ERR,
    input  TOS, DEPTH, EMPTY, FULL, OVF, UDF
  );

  modport slave (
    input  PUSH, POP, DI, CLR_ERR,
    output TOS, DEPTH, EMPTY, FULL, OVF, UDF
  );
endinterface

// File: rtl/czstack.sv
// czstack: call/return stack, TOS register over circular storage.
// Ports: CLK, RST (sync, active-high), bus (czstack_if.slave).
// Build option: CZSTACK_WRAP_EN lets a push while FULL evict the oldest entry.
module czstack #(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_WIDTH = 4
) (
  input  logic     CLK,
  input  logic     RST,
  czstack_if.slave bus
);
  localparam int N = 2 ** STACK_WIDTH;
  localparam logic [STACK_WIDTH:0] DMAX = (STACK_WIDTH+1)'(N);

  typedef logic [STACK_WIDTH-1:0] ptr_t;
  typedef logic [STACK_WIDTH:0]   dep_t;
  typedef logic [PC_WIDTH-1:0]    pc_t;

  pc_t  mem [N];

  // ptr_q: next free slot; top entry lives at ptr_q-1
  ptr_t ptr_q, ptr_d;
  dep_t depth_q, depth_d;
  pc_t  tos_q, tos_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  logic we;
  ptr_t waddr;
  logic empty, full;
  logic do_rep, do_push, do_ovf, do_pop;
  logic ovf_set, udf_set;

  assign empty = (depth_q == '0);
  assign full  = (depth_q == DMAX);

  assign do_rep  = bus.PUSH & bus.POP & ~empty;
  assign do_push = bus.PUSH & ~do_rep & ~full;
  assign do_ovf  = bus.PUSH & ~bus.POP & full;
  assign do_pop  = bus.POP & ~bus.PUSH & ~empty;
  assign ovf_set = do_ovf;
  // empty pop, alone or paired with a push
  assign udf_set = bus.POP & empty;

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    tos_d   = tos_q;
    we      = 1'b0;
    waddr   = ptr_q;
    unique case (1'b1)
      do_rep: begin
        we    = 1'b1;
        waddr = ptr_q - ptr_t'(1);
        tos_d = bus.DI;
      end
      do_push: begin
        we      = 1'b1;
        ptr_d   = ptr_q + ptr_t'(1);
        depth_d = depth_q + dep_t'(1);
        tos_d   = bus.DI;
      end
      do_ovf: begin
`ifdef CZSTACK_WRAP_EN
        // slot at ptr_q holds the oldest entry when full
        we    = 1'b1;
        ptr_d = ptr_q + ptr_t'(1);
        tos_d = bus.DI;
`endif
      end
      do_pop: begin
        ptr_d   = ptr_q - ptr_t'(1);
        depth_d = depth_q - dep_t'(1);
        tos_d   = (depth_q == dep_t'(1)) ? '0
                : mem[ptr_q - ptr_t'(2)];
      end
      default: ;
    endcase
    // set wins over clear
    ovf_d = ovf_set | (ovf_q & ~bus.CLR_ERR);
    udf_d = udf_set | (udf_q & ~bus.CLR_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      depth_q <= '0;
      tos_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      tos_q   <= tos_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (we && !RST) mem[waddr] <= bus.DI;
  end

  assign bus.TOS   = tos_q;
  assign bus.DEPTH = depth_q;
  assign bus.EMPTY = empty;
  assign bus.FULL  = full;
  assign bus.OVF   = ovf_q;
  assign bus.UDF   = udf_q;
endmodule

// File: tb/tb_czstack.sv
// tb_czstack: directed plan plus random ops vs a queue model.
// Works for both default and CZSTACK_WRAP_EN builds.
module tb_czstack;
  localparam int PW = 10;
  localparam int SW = 4;
  localparam int N  = 2 ** SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  czstack_if #(.PC_WIDTH(PW), .STACK_WIDTH(SW)) bus ();

  czstack #(.PC_WIDTH(PW), .STACK_WIDTH(SW)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int  q[$];
  bit  m_ovf = 0;
  bit  m_udf = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(bit r, bit pu, bit po, int di, bit clr);
    bit e, f, no, nu;
    if (r) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    e  = (q.size() == 0);
    f  = (q.size() == N);
    no = 0;
    nu = 0;
    if (pu && po) begin
      if (e) begin
        q.push_back(di);
        nu = 1;
      end else q[q.size()-1] = di;
    end else if (pu) begin
      if (!f) q.push_back(di);
      else begin
        no = 1;
`ifdef CZSTACK_WRAP_EN
        void'(q.pop_front());
        q.push_back(di);
`endif
      end
    end else if (po) begin
      if (e) nu = 1;
      else void'(q.pop_back());
    end
    m_ovf = no | (m_ovf & !clr);
    m_udf = nu | (m_udf & !clr);
  endtask

  task automatic cmp_model();
    int t;
    t = (q.size() > 0) ? q[q.size()-1] : 0;
    chk("m_tos",   32'(bus.TOS),   t);
    chk("m_depth", 32'(bus.DEPTH), q.size());
    chk("m_empty", 32'(bus.EMPTY), 32'(q.size() == 0));
    chk("m_full",  32'(bus.FULL),  32'(q.size() == N));
    chk("m_ovf",   32'(bus.OVF),   32'(m_ovf));
    chk("m_udf",   32'(bus.UDF),   32'(m_udf));
  endtask

  task automatic step(bit r, bit pu, bit po, int di, bit clr);
    rst         = r;
    bus.PUSH    = pu;
    bus.POP     = po;
    bus.DI      = PW'(di);
    bus.CLR_ERR = clr;
    @(posedge clk);
    model(r, pu, po, di, clr);
    #1;
    cmp_model();
  endtask

  int mode;
  int r;

  initial begin
    bus.PUSH    = 1'b0;
    bus.POP     = 1'b0;
    bus.DI      = '0;
    bus.CLR_ERR = 1'b0;

    // reset
    step(1, 0, 0, 0, 0);
    chk("rst_depth", 32'(bus.DEPTH), 0);
    chk("rst_empty", 32'(bus.EMPTY), 1);
    chk("rst_full",  32'(bus.FULL),  0);
    chk("rst_tos",   32'(bus.TOS),   0);
    chk("rst_ovf",   32'(bus.OVF),   0);
    chk("rst_udf",   32'(bus.UDF),   0);

    // push/pop basic
    step(0, 1, 0, 'h123, 0);
    step(0, 1, 0, 'h045, 0);
    chk("pp_tos2",   32'(bus.TOS),   'h045);
    chk("pp_dep2",   32'(bus.DEPTH), 2);
    step(0, 0, 1, 0, 0);
    chk("pp_tos1",   32'(bus.TOS),   'h123);
    chk("pp_dep1",   32'(bus.DEPTH), 1);
    step(0, 0, 1, 0, 0);
    chk("pp_empty",  32'(bus.EMPTY), 1);
    chk("pp_tos0",   32'(bus.TOS),   0);
    chk("pp_dep0",   32'(bus.DEPTH), 0);
    chk("pp_ovf",    32'(bus.OVF),   0);
    chk("pp_udf",    32'(bus.UDF),   0);

    // fill
    for (int i = 1; i <= 16; i++) step(0, 1, 0, i, 0);
    chk("fill_full", 32'(bus.FULL),  1);
    chk("fill_dep",  32'(bus.DEPTH), 16);
    chk("fill_tos",  32'(bus.TOS),   'h010);
`ifdef CZSTACK_WRAP_EN
    step(0, 1, 0, 'h011, 0);
    chk("wr_dep",    32'(bus.DEPTH), 16);
    chk("wr_tos",    32'(bus.TOS),   'h011);
    chk("wr_ovf",    32'(bus.OVF),   1);
    for (int k = 0; k < 16; k++) begin
      chk("wr_popseq", 32'(bus.TOS), 'h011 - k);
      step(0, 0, 1, 0, 0);
    end
`else
    step(0, 1, 0, 'h3FF, 0);
    chk("ov_tos",    32'(bus.TOS),   'h010);
    chk("ov_dep",    32'(bus.DEPTH), 16);
    chk("ov_ovf",    32'(bus.OVF),   1);
    for (int k = 0; k < 16; k++) begin
      chk("ov_popseq", 32'(bus.TOS), 'h010 - k);
      step(0, 0, 1, 0, 0);
    end
`endif
    chk("drain_empty", 32'(bus.EMPTY), 1);
    step(0, 0, 0, 0, 1);
    chk("ovf_clr",   32'(bus.OVF),   0);

    // underflow and clear
    step(0, 0, 1, 0, 0);
    chk("udf_set",   32'(bus.UDF),   1);
    chk("udf_dep",   32'(bus.DEPTH), 0);
    step(0, 0, 1, 0, 1);
    chk("udf_win",   32'(bus.UDF),   1);
    step(0, 0, 0, 0, 1);
    chk("udf_clr",   32'(bus.UDF),   0);

    // simultaneous push+pop
    step(0, 1, 0, 'h011, 0);
    step(0, 1, 0, 'h022, 0);
    step(0, 1, 0, 'h0AA, 0);
    step(0, 1, 1, 'h155, 0);
    chk("rep_tos",   32'(bus.TOS),   'h155);
    chk("rep_dep",   32'(bus.DEPTH), 3);
    chk("rep_ovf",   32'(bus.OVF),   0);
    step(0, 0, 1, 0, 0);
    chk("rep_pop",   32'(bus.TOS),   'h022);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 'h007, 0);
    chk("pe_dep",    32'(bus.DEPTH), 1);
    chk("pe_tos",    32'(bus.TOS),   'h007);
    chk("pe_udf",    32'(bus.UDF),   1);

    // reset mid-operation at depth 5
    for (int i = 0; i < 4; i++) step(0, 1, 0, 'h100 + i, 0);
    chk("mr_pre",    32'(bus.DEPTH), 5);
    step(1, 1, 0, 'h2AB, 0);
    chk("mr_dep",    32'(bus.DEPTH), 0);
    chk("mr_empty",  32'(bus.EMPTY), 1);
    chk("mr_tos",    32'(bus.TOS),   0);
    chk("mr_ovf",    32'(bus.OVF),   0);
    chk("mr_udf",    32'(bus.UDF),   0);

    // random, with phases biased toward full / empty
    for (int s = 0; s < 3000; s++) begin
      mode = (s / 150) % 3;
      r = int'($urandom_range(0, 99));
      case (mode)
        0: step($urandom_range(0, 499) == 0, r < 70, r >= 55,
                int'($urandom_range(0, 1023)), $urandom_range(0, 15) == 0);
        1: step($urandom_range(0, 499) == 0, r < 30, r >= 20,
                int'($urandom_range(0, 1023)), $urandom_range(0, 15) == 0);
        default: step($urandom_range(0, 499) == 0, r < 50, r >= 40,
                int'($urandom_range(0, 1023)), $urandom_range(0, 15) == 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/czstack.md
Name: czstack

Overview:
- Parametrised hardware call/return stack for the CPU core. Successor to the plain stack-RAM block.
- Owns the stack pointer, full/empty status and overflow/underflow detection. Presents the top-of-stack with zero read latency.
- Sits between the sequencer (CALL pushes the return PC, RET pops it) and nothing else. Storage is internal.

Parameters:
- PC_WIDTH, 10, width of each stored entry (return address).
- STACK_WIDTH, 4, log2 of capacity; the stack holds 2**STACK_WIDTH entries.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- PUSH  input  1  push DI this cycle.
- POP  input  1  pop the top entry this cycle.
- DI  input  PC_WIDTH  data to push.
- TOS  output  PC_WIDTH  current top entry, registered state, valid when EMPTY=0.
- DEPTH  output  STACK_WIDTH+1  number of valid entries, 0..2**STACK_WIDTH.
- EMPTY  output  1  DEPTH==0.
- FULL  output  1  DEPTH==2**STACK_WIDTH.
- OVF  output  1  sticky overflow flag.
- UDF  output  1  sticky underflow flag.
- CLR_ERR  input  1  clears OVF and UDF.

Behaviour:
- Reset, synchronous on RST=1 at a rising edge: DEPTH=0, EMPTY=1, FULL=0, OVF=0, UDF=0, TOS=0.
- RST overrides PUSH, POP and CLR_ERR in the same cycle. Storage contents are not reset and are don't-care.
- All outputs are derived from registered state. There is no combinational path from PUSH, POP or DI to any output.
- Latency: an operation sampled at edge n is visible on TOS and DEPTH immediately after edge n.
  - A push of X makes TOS=X.
  - A pop makes TOS equal to the entry pushed before the popped one, with no bubble cycle.
- Operation table, evaluated each cycle with RST=0:
  - PUSH=0, POP=0: hold.
  - PUSH=1, POP=0, not FULL: entry stored, DEPTH+1, TOS=DI.
  - PUSH=1, POP=0, FULL: push rejected; state unchanged; OVF<=1 (see Optional Feature).
  - PUSH=0, POP=1, not EMPTY: DEPTH-1; TOS becomes the next entry down, or 0 when DEPTH becomes 0.
  - PUSH=0, POP=1, EMPTY: no state change; UDF<=1.
  - PUSH=1, POP=1, not EMPTY (including FULL): replace. TOS=DI, DEPTH unchanged, no OVF/UDF. Lower entries are untouched.
  - PUSH=1, POP=1, EMPTY: treated as a push. DEPTH=1, TOS=DI, UDF<=1.
- Sticky flags:
  - OVF and UDF stay set until CLR_ERR=1 or RST.
  - If CLR_ERR=1 and a new error occurs in the same cycle, the flag ends up set (set wins).
- FULL and EMPTY are recomputed from the next DEPTH. Both reflect the post-operation state at edge n.
- Storage is PC_WIDTH x 2**STACK_WIDTH with write-first semantics for the top entry. Implementation choice: TOS register plus array, or pointer plus async-read array. Only the above observable timing is binding.

Optional Feature:
- Macro: CZSTACK_WRAP_EN.
- Undefined (default): push while FULL is rejected as described above.
- Defined:
  - A push while FULL is accepted. The oldest entry (bottom) is discarded.
  - TOS=DI, DEPTH stays 2**STACK_WIDTH, FULL stays 1. OVF is still set, for diagnostic use.
  - Subsequent pops return the newest 2**STACK_WIDTH entries in LIFO order, then EMPTY.
  - This requires circular addressing of the storage; the pointer wraps modulo 2**STACK_WIDTH.
- All other behaviour is identical in both builds.

Test Plan:
- Reset and push/pop: after RST, push 0x123 then 0x045 -> TOS=0x045, DEPTH=2. Pop -> TOS=0x123, DEPTH=1. Pop -> EMPTY=1, TOS=0, DEPTH=0. OVF=UDF=0 throughout.
- Fill and overflow, default build, PC_WIDTH=10, STACK_WIDTH=4:
  - Push 0x001..0x010 -> FULL=1, DEPTH=16, TOS=0x010.
  - Push 0x3FF -> TOS=0x010, DEPTH=16, OVF=1.
  - 16 pops return 0x010..0x001 in order, then EMPTY=1.
- Wrap build (CZSTACK_WRAP_EN): push 0x001..0x011 -> DEPTH=16, TOS=0x011, OVF=1. 16 pops return 0x011..0x002, then EMPTY=1.
- Underflow and clear:
  - Pop on empty -> UDF=1, DEPTH=0.
  - CLR_ERR=1 together with a second empty pop -> UDF stays 1.
  - CLR_ERR alone next cycle -> UDF=0.
- Simultaneous operations:
  - DEPTH=3 with TOS=0x0AA, PUSH=POP=1, DI=0x155 -> TOS=0x155, DEPTH=3. A following pop exposes the original second entry.
  - On empty, PUSH=POP=1, DI=0x007 -> DEPTH=1, TOS=0x007, UDF=1.
- Reset mid-operation: RST=1 asserted together with PUSH=1 at DEPTH=5 -> DEPTH=0, EMPTY=1, TOS=0, OVF=UDF=0 on the next cycle. The push is not performed.
